seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of 7-segment digits that share one `dec_to_7seg`-style BCD decoder. It holds a double-buffered display word and steps through the digits one at a time: it drives the shared decoder input and the active-low digit enables. A guard (blank) interval between digits prevents ghosting. A valid/ready port accepts new display values and applies them only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4 — number of digits scanned; at least 2.
- `DIV`, 50000 — clock cycles each digit is lit per slot; at least 1.
- `BLANK_CYCLES`, 500 — clock cycles all digits are dark before each digit is lit; at least 1.
- `clk` in 1 — single clock; all state on the rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `en` in 1 — scan enable; low forces the display dark and restarts the scan.
- `upd_valid` in 1 — new display word offered.
- `upd_data` in 4*NUM_DIGITS — new word; digit i is `[4i+3:4i]`; digit 0 is least significant.
- `upd_ready` out 1 — high when no update is pending.
- `bcd` out 4 — registered code for the shared decoder input.
- `an` out NUM_DIGITS — registered, active-low digit enables.
- `frame_done` out 1 — one-cycle pulse at the end of each complete frame.

## Operation
- Storage:
  - `active` register: the word being displayed.
  - `pending` register plus `pend_flag`.
  - `upd_ready` = !`pend_flag`.
- Handshake: when `upd_valid` && `upd_ready`, capture `upd_data` into `pending` and set `pend_flag`. `upd_data` is ignored while `upd_ready` is low.
- FSM states and counters:
  - States: BLANK, SHOW.
  - Digit index `dig` runs 0..NUM_DIGITS-1.
  - Cycle counter `cnt`.
- BLANK:
  - `an` is all ones and `bcd` = `active[dig]`.
  - Counts `cnt` from 0 to BLANK_CYCLES-1, then goes to SHOW with `cnt` = 0.
- SHOW:
  - `an[dig]` = 0 and all other bits of `an` = 1, unless the digit is suppressed (see Configuration).
  - Counts `cnt` from 0 to DIV-1, then goes to BLANK with `dig` = `dig`+1.
  - `dig` wraps from NUM_DIGITS-1 to 0.
- Frame end is the last SHOW cycle of digit NUM_DIGITS-1. On the following edge:
  - `frame_done` pulses.
  - If `pend_flag` is set, `active` <= `pending` and `pend_flag` clears.
- Codes 10–15 pass through unmodified; the decoder handles them.
- `en` low:
  - On the next edge the block enters BLANK with `dig` = 0, `cnt` = 0 and `an` all ones.
  - It stays there while `en` is low, with no `frame_done` pulse.
  - `pending` and `pend_flag` are retained and the handshake still operates.
- Reset values:
  - State BLANK, `dig` = 0, `cnt` = 0.
  - `active` = 0, `pending` = 0, `pend_flag` = 0.
  - `an` = all ones, `bcd` = 0, `frame_done` = 0, so `upd_ready` = 1.

## Timing
- Slot = BLANK_CYCLES + DIV cycles. Frame = NUM_DIGITS × slot.
- `bcd` changes only on the first BLANK cycle of a slot. It is therefore stable for at least BLANK_CYCLES before any `an` bit goes low, and for the whole SHOW interval.
- Each `an` bit is low for exactly DIV consecutive cycles per frame; there is never more than one bit low.
- Handshake:
  - `upd_ready` falls on the edge after acceptance.
  - It rises on the edge where `pending` is transferred to `active`.
  - The earliest that transferred data appears on `bcd` is the first slot of the next frame.
- Acceptance in the frame-end cycle itself (possible only if `pend_flag` was clear) sets `pend_flag`. That data is applied at the next frame end, not the current one.
- Asynchronous reset mid-slot: outputs return to reset values immediately, and scanning restarts at digit 0 after `rst_n` rises.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero suppression.
  - Digit i > 0 is suppressed if `active[j]` == 0 for every j ≥ i.
  - A suppressed digit keeps its `an` bit high during its SHOW interval; slot timing is unchanged.
  - Digit 0 is never suppressed.
- `SEG7_LZ_BLANK_EN` undefined: every digit is lit in its SHOW interval regardless of value.

## Test plan
- Reset, then DIV=4, BLANK_CYCLES=2, NUM_DIGITS=4, `en`=1 -> `an` cycles 1111,1111,1110×4, 1111×2, 1101×4, …; first `frame_done` pulse at cycle 24.
- Write 0x4321 via `upd_valid` mid-frame -> `upd_ready` low next cycle; `bcd` stays 0 until the next frame; then `bcd` shows 1,2,3,4 per slot; `upd_ready` returns high at the frame end.
- Offer a second word 0x8765 while `pend_flag` is set -> it is not accepted (`upd_ready`=0); it is accepted after the frame end and displayed one frame later.
- Drop `en` during SHOW of digit 2 -> `an`=1111 next cycle, no `frame_done`; raise `en` -> the scan restarts at digit 0 BLANK.
- Assert `rst_n`=0 mid-SHOW -> `an`=1111, `bcd`=0 and `upd_ready`=1 without waiting for a clock edge.
- With `SEG7_LZ_BLANK_EN`, display 0x0070 -> digits 3 and 2 are never lit; digit 1 shows 7; digit 0 shows 0. Display 0x0000 -> only digit 0 is lit.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_ctrl_if
// Display-update port of seg7_scan_ctrl.
//
// Handshake: a word transfers on every rising clock edge where upd_valid and
// upd_ready are both high. The master holds upd_valid/upd_data stable until
// that edge. The slave keeps upd_ready low while it still holds an earlier
// word that it has not yet used.
//
// Signals
//   upd_valid  master->slave  new display word offered
//   upd_data   master->slave  4 bits per digit, digit 0 in [3:0]
//   upd_ready  slave->master  high when the slave can take a word
// ----------------------------------------------------------------------------
interface seg7_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    upd_valid;
  logic [4*NUM_DIGITS-1:0] upd_data;
  logic                    upd_ready;

  modport master (output upd_valid, output upd_data, input upd_ready);
  modport slave  (input upd_valid, input upd_data, output upd_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg7_scan_ctrl
// Scan controller for time-multiplexed 7-segment digits. The digits share one
// BCD decoder. Each digit slot starts with a dark guard interval of
// BLANK_CYCLES, during which bcd settles. The digit is then lit for DIV cycles.
// New display words are double-buffered. They take effect only at a frame
// boundary, so one frame never mixes old and new digits.
//
// Optional feature macro: SEG7_LZ_BLANK_EN. When it is defined, leading zeros
// are suppressed: a digit above 0 whose value and all higher digits are zero
// stays dark. Slot timing does not change.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   en           scan enable; low keeps the display dark and restarts the scan
//   upd_if       slave side of the valid/ready update port
//   bcd          registered code for the shared decoder
//   an           registered active-low digit enables
//   frame_done   one-cycle pulse after each complete frame
//   dbg_state_o  current scan state (0 = BLANK, 1 = SHOW)
// ----------------------------------------------------------------------------
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  seg7_scan_ctrl_if.slave       upd_if,
  output logic [3:0]            bcd,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  frame_done,
  output logic                  dbg_state_o
);

  localparam int CNT_MAX = (DIV > BLANK_CYCLES) ? DIV : BLANK_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DW      = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t                    state_q;
  logic [DW-1:0]             dig_q;
  logic [CW-1:0]             cnt_q;
  logic [4*NUM_DIGITS-1:0]   active_q;
  logic [4*NUM_DIGITS-1:0]   pending_q;
  logic                      pend_q;
  logic [3:0]                bcd_q;
  logic [NUM_DIGITS-1:0]     an_q;
  logic                      frame_done_q;
  logic [NUM_DIGITS-1:0]     sup;

  logic [3:0] act_dig [NUM_DIGITS];
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    assign act_dig[g] = active_q[4*g +: 4];
  end

`ifdef SEG7_LZ_BLANK_EN
  // A digit is suppressed when it and every digit above it are zero.
  // Digit 0 is never suppressed.
  logic zero_above;
  always_comb begin
    zero_above = 1'b1;
    sup        = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above & (act_dig[i] == 4'd0);
      sup[i]     = zero_above;
    end
  end
`else
  assign sup = '0;
`endif

  assign upd_if.upd_ready = !pend_q;
  assign bcd              = bcd_q;
  assign an               = an_q;
  assign frame_done       = frame_done_q;
  assign dbg_state_o      = (state_q == ST_SHOW);

  // The an and bcd registers are loaded on the same edge that enters a state.
  // Their values therefore match the state that becomes current at that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BLANK;
      dig_q        <= '0;
      cnt_q        <= '0;
      active_q     <= '0;
      pending_q    <= '0;
      pend_q       <= 1'b0;
      bcd_q        <= 4'd0;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;

      // The handshake runs regardless of en.
      // A word arriving in the frame-end cycle waits for the next frame end.
      if (upd_if.upd_valid && !pend_q) begin
        pending_q <= upd_if.upd_data;
        pend_q    <= 1'b1;
      end

      if (!en) begin
        state_q <= ST_BLANK;
        dig_q   <= '0;
        cnt_q   <= '0;
        an_q    <= '1;
        bcd_q   <= act_dig[0];
      end else begin
        case (state_q)
          ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              state_q <= ST_SHOW;
              cnt_q   <= '0;
              an_q    <= ~(NUM_DIGITS'(1) << dig_q) | sup;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_SHOW: begin
            if (cnt_q == DIV_LAST) begin
              state_q <= ST_BLANK;
              cnt_q   <= '0;
              an_q    <= '1;
              if (dig_q == DIG_LAST) begin
                // Frame end: this is the only point where a pending word
                // replaces the displayed word.
                dig_q        <= '0;
                frame_done_q <= 1'b1;
                if (pend_q) begin
                  active_q <= pending_q;
                  pend_q   <= 1'b0;
                  bcd_q    <= pending_q[3:0];
                end else begin
                  bcd_q <= act_dig[0];
                end
              end else begin
                dig_q <= dig_q + DW'(1);
                bcd_q <= act_dig[dig_q + DW'(1)];
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= ST_BLANK;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl with DIV=4, BLANK_CYCLES=2 and
// NUM_DIGITS=4. The reference model tracks the elapsed scan time since the
// last restart. From that time it works out the slot, the digit and the
// phase with plain arithmetic. Words accepted on the update port wait in a
// queue and become the displayed word at a frame end. If SEG7_LZ_BLANK_EN is
// defined, the model also applies leading-zero suppression.
// ----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;
  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int BLK   = 2;
  localparam int SLOT  = DIV + BLK;
  localparam int FRAME = N * SLOT;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic [3:0]   bcd;
  logic [N-1:0] an;
  logic         frame_done;
  logic         dbg_state;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NUM_DIGITS(N)) upd_if ();

  seg7_scan_ctrl #(
    .NUM_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(BLK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .upd_if(upd_if.slave),
    .bcd(bcd), .an(an), .frame_done(frame_done), .dbg_state_o(dbg_state)
  );

  // ---------------- reference model ----------------
  int            m_t;          // cycles of scanning since the last restart
  logic [15:0]   m_active;
  logic          m_fd;
  logic [15:0]   exp_q[$];     // accepted words that are not yet displayed

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [3:0] nibble(input logic [15:0] w, input int d);
    logic [15:0] s;
    s = w >> (4 * d);
    return s[3:0];
  endfunction

  function automatic logic suppressed(input int d);
`ifdef SEG7_LZ_BLANK_EN
    logic [15:0] s;
    s = m_active >> (4 * d);
    return (d > 0) && (s == 16'd0);
`else
    return (d < 0);
`endif
  endfunction

  function automatic logic [N-1:0] exp_an();
    int pos;
    int d;
    pos = m_t % SLOT;
    d   = (m_t / SLOT) % N;
    if (pos < BLK || suppressed(d)) return '1;
    return ~(N'(1) << d);
  endfunction

  function automatic logic [3:0] exp_bcd();
    return nibble(m_active, (m_t / SLOT) % N);
  endfunction

  task automatic model_reset();
    m_t      = 0;
    m_active = '0;
    m_fd     = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic fe;
    logic acc;
    fe  = en && (m_t % FRAME == FRAME - 1);
    acc = upd_if.upd_valid && (exp_q.size() == 0);
    if (!en) m_t = 0;
    else     m_t++;
    m_fd = fe;
    if (fe && exp_q.size() != 0) m_active = exp_q.pop_front();
    else if (acc) exp_q.push_back(upd_if.upd_data);
  endtask

  task automatic check_outputs();
    check_eq("an", 32'(an), 32'(exp_an()));
    check_eq("bcd", 32'(bcd), 32'(exp_bcd()));
    check_eq("frame_done", 32'(frame_done), 32'(m_fd));
    check_eq("upd_ready", 32'(upd_if.upd_ready), 32'(exp_q.size() == 0));
    check_eq("state", 32'(dbg_state), 32'((m_t % SLOT) >= BLK));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check_outputs();
  endtask

  // Hold the word on the port until the model says it was taken.
  task automatic offer(input logic [15:0] w);
    logic taken;
    logic acc_now;
    taken = 1'b0;
    upd_if.upd_valid = 1'b1;
    upd_if.upd_data  = w;
    for (int i = 0; i < 3 * FRAME && !taken; i++) begin
      acc_now = (exp_q.size() == 0);
      step();
      taken = acc_now;
    end
    if (!taken) check_eq("offer_timeout", 32'd0, 32'd1);
    upd_if.upd_valid = 1'b0;
  endtask

  task automatic run_until_phase(input int modulus, input int phase);
    int n;
    n = 0;
    while ((m_t % modulus) != phase && n < 2 * FRAME) begin
      step();
      n++;
    end
    if ((m_t % modulus) != phase) check_eq("phase_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    upd_if.upd_valid = 1'b0;
    upd_if.upd_data  = '0;
    model_reset();

    // Reset values, then a first plain frame with the display word at zero.
    repeat (3) step();
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (30) step();

    // Mid-frame write. A second word held while the first is pending must
    // wait for the frame end.
    offer(16'h4321);
    offer(16'h8765);
    repeat (60) step();

    // Words with leading zeros.
    offer(16'h0070);
    repeat (2 * FRAME) step();
    offer(16'h0000);
    repeat (2 * FRAME) step();
    offer(16'h0a0f);
    repeat (FRAME) step();

    // Drop en during SHOW of digit 2, then resume.
    run_until_phase(FRAME, 2 * SLOT + BLK + 1);
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (30) step();

    // Asynchronous reset in the middle of a SHOW interval.
    upd_if.upd_valid = 1'b1;
    upd_if.upd_data  = 16'h9abc;
    step();
    upd_if.upd_valid = 1'b0;
    run_until_phase(SLOT, BLK + 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (30) step();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      int nz;
      int mask;
      en               = ($urandom_range(0, 49) != 0);
      upd_if.upd_valid = ($urandom_range(0, 3) == 0);
      nz               = $urandom_range(0, 4);
      mask             = (1 << (4 * nz)) - 1;
      upd_if.upd_data  = 16'($urandom & mask);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
